core_run_ctrl: RTL and testbench

Run sequencer and data-memory arbiter for the 9-bit single-cycle core. It holds the core in reset while the host (testbench or loader) owns data memory, boots the core on a host request, and counts execution cycles. It stops the run on the core's done flag or on a watchdog timeout, then returns memory ownership to the host for readback. It sits between the host port, the core's data-memory port and the single `dat_mem` instance.

---
 rtl/core_run_ctrl.sv | 123 ++++++++++++
 tb/tb_core_run_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// Run sequencer and data-memory arbiter for the 9-bit core: boots the core on a
// host request, counts RUN cycles, stops on done or watchdog, and muxes dat_mem.
module core_run_ctrl #(
  parameter int             AW      = 8,
  parameter int             DW      = 8,
  parameter int             TW      = 16,
  parameter logic [TW-1:0]  TIMEOUT = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          host_wr_en,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdat,
  output logic [DW-1:0] host_rdat,
  input  logic          core_wr_en,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdat,
  output logic [DW-1:0] core_rdat,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdat,
  output logic          core_rst,
  input  logic          core_done,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [TW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {IDLE, BOOT, RUN, HALT} state_t;

  localparam logic [TW-1:0] CNT_ONE = {{(TW-1){1'b0}}, 1'b1};

  state_t state;
  logic   req_q;
  logic   boot_cnt;

  // req_q resets high so a request already asserted during reset is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= 1'b1;
      boot_cnt  <= 1'b0;
      cycle_cnt <= '0;
      timeout   <= 1'b0;
      core_rst  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      req_q <= req;
      case (state)
        IDLE: begin
          if (req && !req_q) begin
            state     <= BOOT;
            boot_cnt  <= 1'b0;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
            busy      <= 1'b1;
          end
        end
        BOOT: begin
          if (boot_cnt) begin
            state    <= RUN;
            core_rst <= 1'b0;
          end else begin
            boot_cnt <= 1'b1;
          end
        end
        RUN: begin
          // core_done takes priority over the watchdog in the same cycle
          if (core_done) begin
            state    <= HALT;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (cycle_cnt == TIMEOUT) begin
            state    <= HALT;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
          end
        end
        HALT: begin
          if (!req) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ownership follows the state register, so it flips on the same edge as the state.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdat  = '0;
    host_rdat = '0;
    core_rdat = '0;
    case (state)
      IDLE, HALT: begin
        mem_wr_en = host_wr_en;
        mem_addr  = host_addr;
        mem_wdat  = host_wdat;
        host_rdat = mem_rdat;
      end
      RUN: begin
        mem_wr_en = core_wr_en;
        mem_addr  = core_addr;
        mem_wdat  = core_wdat;
        core_rdat = mem_rdat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Randomized bench for core_run_ctrl: a cycle-level behavioural model with its own
// reference memory is compared against the DUT on every falling edge.
module tb_core_run_ctrl;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TW  = 16;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b1;
  logic          host_wr_en = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdat = '0;
  logic [DW-1:0] host_rdat;
  logic          core_wr_en = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdat = '0;
  logic [DW-1:0] core_rdat;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdat;
  logic [DW-1:0] mem_rdat;
  logic          core_rst;
  logic          core_done = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [TW-1:0] cycle_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  // model state: run phases described by counters rather than an encoded state
  bit m_req_prev = 1'b1;
  int m_boot_left = 0;
  bit m_running = 1'b0;
  bit m_finished = 1'b0;
  int m_cnt = 0;
  bit m_to = 1'b0;

  core_run_ctrl #(.AW(AW), .DW(DW), .TW(TW), .TIMEOUT(16'd20)) dut (
    .clk(clk), .reset(reset), .req(req),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wdat(host_wdat), .host_rdat(host_rdat),
    .core_wr_en(core_wr_en), .core_addr(core_addr), .core_wdat(core_wdat), .core_rdat(core_rdat),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
    .core_rst(core_rst), .core_done(core_done), .busy(busy), .done(done),
    .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // stand-in for dat_mem: synchronous write, combinational read
  assign mem_rdat = mem[mem_addr];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      if (mem_wr_en) mem[mem_addr] <= mem_wdat;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model, advanced on every rising edge or on reset assertion
  initial begin
    bit owner_busy;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_req_prev = 1'b1; m_boot_left = 0; m_running = 1'b0;
        m_finished = 1'b0; m_cnt = 0; m_to = 1'b0;
      end else begin
        owner_busy = (m_boot_left > 0) || m_running;
        if (!owner_busy && host_wr_en) ref_mem[host_addr] = host_wdat;
        else if (m_running && core_wr_en) ref_mem[core_addr] = core_wdat;
        if (m_running) begin
          if (core_done) begin
            m_running = 1'b0; m_finished = 1'b1;
          end else if (m_cnt == TMO) begin
            m_running = 1'b0; m_finished = 1'b1; m_to = 1'b1;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else if (m_boot_left > 0) begin
          m_boot_left = m_boot_left - 1;
          if (m_boot_left == 0) m_running = 1'b1;
        end else if (m_finished) begin
          if (!req) m_finished = 1'b0;
        end else if (req && !m_req_prev) begin
          m_boot_left = 2; m_cnt = 0; m_to = 1'b0;
        end
        m_req_prev = req;
      end
    end
  end

  // compare process: every falling edge
  initial begin
    bit own_h, own_c;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdat, e_hr, e_cr;
    forever begin
      @(negedge clk);
      own_h = !((m_boot_left > 0) || m_running);
      own_c = m_running;
      e_we = 1'b0; e_addr = '0; e_wdat = '0; e_hr = '0; e_cr = '0;
      if (own_h) begin
        e_we = host_wr_en; e_addr = host_addr; e_wdat = host_wdat; e_hr = ref_mem[host_addr];
      end else if (own_c) begin
        e_we = core_wr_en; e_addr = core_addr; e_wdat = core_wdat; e_cr = ref_mem[core_addr];
      end
      check("core_rst", core_rst, !m_running);
      check("busy", busy, !own_h);
      check("done", done, m_finished);
      check("timeout", timeout, m_to);
      check("cycle_cnt", cycle_cnt, m_cnt);
      check("mem_wr_en", mem_wr_en, e_we);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdat", mem_wdat, e_wdat);
      check("host_rdat", host_rdat, e_hr);
      check("core_rdat", core_rdat, e_cr);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_bus(input bit host_writes);
    core_wr_en = 1'($urandom_range(0, 1));
    core_addr  = AW'($urandom);
    core_wdat  = DW'($urandom);
    host_wr_en = host_writes ? 1'($urandom_range(0, 1)) : 1'b0;
    host_addr  = AW'($urandom);
    host_wdat  = DW'($urandom);
  endtask

  task automatic apply_stimulus(input int n, input bit toggle_req);
    int  k;
    int  exp_cnt;
    bit  exp_to;
    exp_cnt = (n > TMO) ? TMO : n;
    exp_to  = (n > TMO);
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_bus(1'b1);
      core_done = 1'($urandom_range(0, 1));
      cycle();
    end
    core_done = 1'b0;
    rand_bus(1'b1);
    req = 1'b1;
    cycle();
    check("boot1_core_rst", core_rst, 1);
    check("boot1_busy", busy, 1);
    if (toggle_req) req = 1'b0;
    cycle();
    check("boot2_core_rst", core_rst, 1);
    if (toggle_req) req = 1'b1;
    cycle();
    check("run_core_rst_low", core_rst, 0);
    k = 0;
    while (busy && k < 200) begin
      core_done = (k == n);
      if (toggle_req) req = 1'($urandom_range(0, 1));
      rand_bus(1'b1);
      cycle();
      k++;
    end
    core_done = 1'b0;
    core_wr_en = 1'b0;
    host_wr_en = 1'b0;
    check("run_bounded", (k < 200) ? 1 : 0, 1);
    check("run_cycles", k, (n > TMO) ? TMO + 1 : n + 1);
    check_output(exp_cnt, exp_to);
    req = 1'b0;
    cycle();
    cycle();
    check("idle_done_low", done, 0);
    check("idle_cnt_held", cycle_cnt, exp_cnt);
    check("idle_to_held", timeout, exp_to);
  endtask

  task automatic check_output(input int exp_cnt, input bit exp_to);
    check("halt_done", done, 1);
    check("halt_busy", busy, 0);
    check("halt_core_rst", core_rst, 1);
    check("halt_cycle_cnt", cycle_cnt, exp_cnt);
    check("halt_timeout", timeout, exp_to);
    check("halt_host_owns", mem_addr, host_addr);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req   = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_core_rst", core_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    reset = 1'b0;
    repeat (4) cycle();
    check("req_held_no_run", busy, 0);
    check("req_held_core_rst", core_rst, 1);
    req = 1'b0;
    cycle();

    host_wr_en = 1'b1; host_addr = 8'h40; host_wdat = 8'hA5;
    core_wr_en = 1'b1; core_addr = 8'h40; core_wdat = 8'h5A;
    cycle();
    host_wr_en = 1'b0;
    #1;
    check("idle_core_wr_blocked", mem_wr_en, 0);
    cycle();
    check("host_readback", host_rdat, 8'hA5);
    check("idle_core_rdat", core_rdat, 0);
    core_wr_en = 1'b0;

    apply_stimulus(10, 1'b0);
    apply_stimulus(30, 1'b0);
    apply_stimulus(5, 1'b1);
    apply_stimulus(TMO, 1'b0);
    apply_stimulus(0, 1'b0);
    for (int r = 0; r < 8; r++)
      apply_stimulus(int'($urandom_range(0, 26)), 1'($urandom_range(0, 1)));

    // reset in the middle of a run while the core is storing
    host_wr_en = 1'b1; host_addr = 8'h33; host_wdat = 8'h11;
    cycle();
    host_wr_en = 1'b0; core_wr_en = 1'b0; core_done = 1'b0;
    req = 1'b1;
    repeat (6) cycle();
    check("midrun_busy", busy, 1);
    core_wr_en = 1'b1; core_addr = 8'h33; core_wdat = 8'h99;
    reset = 1'b1;
    #1;
    check("midrun_rst_core_rst", core_rst, 1);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_mem_wr", mem_wr_en, 0);
    check("midrun_rst_cnt", cycle_cnt, 0);
    cycle();
    reset = 1'b0; core_wr_en = 1'b0; req = 1'b0; host_addr = 8'h33;
    #1;
    check("midrun_write_dropped", host_rdat, 8'h11);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
